mod_n_down_timer: RTL and testbench



---
 rtl/mod_n_down_timer_if.sv | 24 ++
 rtl/mod_n_down_timer.sv | 106 ++++++++++
 tb/tb_mod_n_down_timer.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/mod_n_down_timer_if.sv
// Control/status bundle for mod_n_down_timer: the owner drives load/start/pause
// and observes count, busy, tc and load_err.
interface mod_n_down_timer_if #(
  parameter int WIDTH = 4
);
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             start;
  logic             pause;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             tc;
  logic             load_err;

  modport master (
    output load, load_val, start, pause,
    input  count, busy, tc, load_err
  );

  modport slave (
    input  load, load_val, start, pause,
    output count, busy, tc, load_err
  );
endinterface

// File: rtl/mod_n_down_timer.sv
// Loadable modulo-MOD down counter with a one-cycle terminal-count pulse.
// Define AUTO_RELOAD_EN to reload the last preset on terminal count and keep running.
//
//   state    | meaning
//   ---------+-----------------------------------------------
//   ST_IDLE  | count held; start launches a run if count != 0
//   ST_RUN   | count decrements on each unpaused edge
module mod_n_down_timer #(
  parameter int WIDTH = 4,
  parameter int MOD   = 12
) (
  input  logic              clk,
  input  logic              reset,
  mod_n_down_timer_if.slave tmr
);

  localparam logic [0:0]       ST_IDLE = 1'b0;
  localparam logic [0:0]       ST_RUN  = 1'b1;
  localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MOD - 1);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             busy_q, busy_d;
  logic             tc_q, tc_d;
  logic             load_err_q, load_err_d;
  logic             load_ok;
  logic [WIDTH-1:0] load_cnt;
`ifdef AUTO_RELOAD_EN
  logic [WIDTH-1:0] preset_q, preset_d;
`endif

  // Out-of-range presets clamp to the top legal value rather than being dropped.
  assign load_ok  = (tmr.load_val <= MAX_CNT);
  assign load_cnt = load_ok ? tmr.load_val : MAX_CNT;

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    tc_d       = 1'b0;
    load_err_d = load_err_q;
`ifdef AUTO_RELOAD_EN
    preset_d   = preset_q;
`endif
    if (tmr.load) begin
      state_d    = ST_IDLE;
      count_d    = load_cnt;
      load_err_d = !load_ok;
`ifdef AUTO_RELOAD_EN
      preset_d   = load_cnt;
`endif
    end else if (state_q == ST_IDLE) begin
      if (tmr.start) begin
        if (count_q != '0) begin
          state_d = ST_RUN;
        end else begin
          tc_d = 1'b1;
        end
      end
    end else if (!tmr.pause) begin
      if (count_q == ONE) begin
        tc_d = 1'b1;
`ifdef AUTO_RELOAD_EN
        count_d = preset_q;
`else
        count_d = '0;
        state_d = ST_IDLE;
`endif
      end else if (count_q != '0) begin
        count_d = count_q - ONE;
      end else begin
        // A zero count in RUN is unreachable; fall back to IDLE without wrapping.
        state_d = ST_IDLE;
      end
    end
    busy_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      busy_q     <= 1'b0;
      tc_q       <= 1'b0;
      load_err_q <= 1'b0;
`ifdef AUTO_RELOAD_EN
      preset_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      busy_q     <= busy_d;
      tc_q       <= tc_d;
      load_err_q <= load_err_d;
`ifdef AUTO_RELOAD_EN
      preset_q   <= preset_d;
`endif
    end
  end

  assign tmr.count    = count_q;
  assign tmr.busy     = busy_q;
  assign tmr.tc       = tc_q;
  assign tmr.load_err = load_err_q;

endmodule

// File: tb/tb_mod_n_down_timer.sv
// Bench for mod_n_down_timer: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against an integer reference model.
module tb_mod_n_down_timer;
  localparam int WIDTH = 4;
  localparam int MOD   = 12;
`ifdef AUTO_RELOAD_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  bit   chk_en = 1'b0;

  mod_n_down_timer_if #(.WIDTH(WIDTH)) tif ();

  mod_n_down_timer #(.WIDTH(WIDTH), .MOD(MOD)) dut (
    .clk  (clk),
    .reset(reset),
    .tmr  (tif)
  );

  always #5 clk = ~clk;

  // Reference model: the timer as remaining ticks held in plain integers.
  int m_count  = 0;
  int m_preset = 0;
  bit m_run    = 1'b0;
  bit m_tc     = 1'b0;
  bit m_err    = 1'b0;

  always @(posedge clk) begin
    m_tc = 1'b0;
    if (reset) begin
      m_count  = 0;
      m_preset = 0;
      m_run    = 1'b0;
      m_err    = 1'b0;
    end else if (tif.load) begin
      m_err    = (int'(tif.load_val) > MOD - 1);
      m_count  = m_err ? MOD - 1 : int'(tif.load_val);
      m_preset = m_count;
      m_run    = 1'b0;
    end else if (!m_run) begin
      if (tif.start) begin
        if (m_count == 0) m_tc = 1'b1;
        else m_run = 1'b1;
      end
    end else if (!tif.pause) begin
      m_count = m_count - 1;
      if (m_count == 0) begin
        m_tc = 1'b1;
        if (AR) m_count = m_preset;
        else m_run = 1'b0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Literal expectation applied to both the DUT and the model.
  task automatic lit(input string name, input logic [31:0] dut_v, input logic [31:0] mdl_v,
                     input logic [31:0] exp);
    chk(name, dut_v, exp);
    chk({name, "_model"}, mdl_v, exp);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_count", 32'(tif.count), m_count);
      chk("cyc_busy", 32'(tif.busy), 32'(m_run));
      chk("cyc_tc", 32'(tif.tc), 32'(m_tc));
      chk("cyc_load_err", 32'(tif.load_err), 32'(m_err));
    end
  end

  task automatic step(input bit ld, input int lv, input bit st, input bit ps, input bit rs);
    tif.load     = ld;
    tif.load_val = WIDTH'(lv);
    tif.start    = st;
    tif.pause    = ps;
    reset        = rs;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    tif.load = 1'b0; tif.load_val = '0; tif.start = 1'b0; tif.pause = 1'b0;
    reset = 1'b1;

    // Reset
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    chk_en = 1'b1;
    lit("rst_count", tif.count, m_count, 0);
    lit("rst_busy", tif.busy, m_run, 0);
    lit("rst_tc", tif.tc, m_tc, 0);
    lit("rst_err", tif.load_err, m_err, 0);

    // One-shot from 5: tc in the sixth cycle after the start edge
    step(1, 5, 0, 0, 0);
    lit("os_load", tif.count, m_count, 5);
    step(0, 0, 1, 0, 0);
    lit("os_start_count", tif.count, m_count, 5);
    lit("os_start_busy", tif.busy, m_run, 1);
    for (int k = 1; k <= 5; k++) begin
      idle();
      lit("os_count", tif.count, m_count, (k < 5) ? 5 - k : (AR ? 5 : 0));
      lit("os_tc", tif.tc, m_tc, 32'(k == 5));
      lit("os_busy", tif.busy, m_run, 32'((k < 5) || AR));
    end
    idle();
    lit("os_tc_width", tif.tc, m_tc, 0);
    step(1, 0, 0, 0, 0);

    // Range check and clamp boundaries
    step(1, 13, 0, 0, 0);
    lit("rng13_count", tif.count, m_count, 11);
    lit("rng13_err", tif.load_err, m_err, 1);
    idle();
    lit("rng_sticky", tif.load_err, m_err, 1);
    step(1, 3, 0, 0, 0);
    lit("rng3_count", tif.count, m_count, 3);
    lit("rng3_err", tif.load_err, m_err, 0);
    step(1, 11, 0, 0, 0);
    lit("rng11_err", tif.load_err, m_err, 0);
    step(1, 12, 0, 0, 0);
    lit("rng12_count", tif.count, m_count, 11);
    lit("rng12_err", tif.load_err, m_err, 1);
    step(1, 15, 0, 0, 0);
    lit("rng15_count", tif.count, m_count, 11);

    // Pause: load 4, pause three cycles at count 2, tc in the eighth cycle
    step(1, 4, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    idle();
    idle();
    lit("pz_count2", tif.count, m_count, 2);
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 0, 1, 0);
      lit("pz_hold", tif.count, m_count, 2);
      lit("pz_busy", tif.busy, m_run, 1);
    end
    idle();
    lit("pz_count1", tif.count, m_count, 1);
    lit("pz_no_tc", tif.tc, m_tc, 0);
    idle();
    lit("pz_tc", tif.tc, m_tc, 1);
    lit("pz_final", tif.count, m_count, AR ? 4 : 0);

    // Abort at count 1
    step(1, 3, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    idle();
    idle();
    lit("ab_count1", tif.count, m_count, 1);
    step(1, 7, 0, 0, 0);
    lit("ab_count", tif.count, m_count, 7);
    lit("ab_busy", tif.busy, m_run, 0);
    lit("ab_tc", tif.tc, m_tc, 0);
    idle();
    lit("ab_tc_later", tif.tc, m_tc, 0);

    // Start with count 0
    step(1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    lit("z_tc", tif.tc, m_tc, 1);
    lit("z_busy", tif.busy, m_run, 0);
    idle();
    lit("z_tc_off", tif.tc, m_tc, 0);

    // load+start together, then reset mid-run
    step(1, 6, 1, 0, 0);
    lit("ls_count", tif.count, m_count, 6);
    lit("ls_busy", tif.busy, m_run, 0);
    step(0, 0, 1, 0, 0);
    lit("rr_busy", tif.busy, m_run, 1);
    step(0, 0, 0, 0, 1);
    lit("rr_count", tif.count, m_count, 0);
    lit("rr_busy0", tif.busy, m_run, 0);

    // Load on the terminal-count edge suppresses tc
    step(1, 2, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    idle();
    step(1, 9, 0, 0, 0);
    lit("ltc_count", tif.count, m_count, 9);
    lit("ltc_tc", tif.tc, m_tc, 0);
    lit("ltc_busy", tif.busy, m_run, 0);

`ifdef AUTO_RELOAD_EN
    step(1, 3, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    for (int k = 1; k <= 12; k++) begin
      idle();
      lit("ar_count", tif.count, m_count, (k % 3 == 0) ? 3 : 3 - (k % 3));
      lit("ar_tc", tif.tc, m_tc, 32'(k % 3 == 0));
      lit("ar_busy", tif.busy, m_run, 1);
    end
    step(1, 0, 0, 0, 0);
    lit("ar_stop_busy", tif.busy, m_run, 0);
    lit("ar_stop_count", tif.count, m_count, 0);
`endif

    // Randomized traffic, checked every cycle by the compare process
    for (int n = 0; n < 3000; n++) begin
      int r;
      int lv;
      r  = int'($urandom_range(0, 99));
      lv = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(1, 5));
      step(r < 8, lv, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, r == 99);
    end

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
